// File: rtl/video_pll_seq_pkg.sv
// Shared types and sizing helpers for the video PLL lock sequencer.
package video_pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        FAULT
    } seq_state_e;

    // The shared counter only ever holds (cycles - 1), so clog2 of the largest cycle count suffices.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/video_pll_seq_sync.sv
// Two-flop bit synchronizer with asynchronous active-low reset to 0.
module video_pll_seq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: flops use non-blocking assignment so both stages sample the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/video_pll_lock_sequencer.sv
// Video PLL reset/lock sequencer with retry, fault latch and soft restart.
// Optional lock-loss counter enabled by defining VIDEO_PLL_SEQ_LOSS_COUNT_EN.
module video_pll_lock_sequencer
    import video_pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               pll_locked,
    input  logic                               soft_restart,
    output logic                               pll_rst,
    output logic                               video_rst_n,
    output logic                               ready,
    output logic                               fault,
`ifdef VIDEO_PLL_SEQ_LOSS_COUNT_EN
    output logic [7:0]                         lock_loss_count,
`endif
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int CNT_W   = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

    localparam logic [CNT_W-1:0]   RST_LOAD    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LOAD     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    logic locked_s;

    video_pll_seq_sync #(.WIDTH(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, pll_rst_d;
    logic               video_rst_n_q, video_rst_n_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

        unique case (state_q)
            RESET_PLL: if (cnt_q == '0) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                end else if (cnt_q == '0) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (retry_d == RETRY_MAX) ? FAULT : RESET_PLL;
                end
            end
            STABILIZE: begin
                if (!locked_s)          state_d = WAIT_LOCK;
                else if (cnt_q == '0)   state_d = RUN;
            end
            RUN:       if (!locked_s) state_d = RESET_PLL;
            FAULT:     state_d = FAULT;
            default:   state_d = RESET_PLL;
        endcase

        if (state_d == RUN && state_q != RUN) retry_d = '0;

        if (soft_restart) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end

        // Any state entry, including a restart of RESET_PLL itself, starts a fresh count.
        if (state_d != state_q || soft_restart) begin
            unique case (state_d)
                RESET_PLL: cnt_d = RST_LOAD;
                WAIT_LOCK: cnt_d = TO_LOAD;
                STABILIZE: cnt_d = STABLE_LOAD;
                default:   cnt_d = '0;
            endcase
        end

        pll_rst_d     = (state_d == RESET_PLL) || (state_d == FAULT);
        video_rst_n_d = (state_d == RUN);
        ready_d       = (state_d == RUN);
        fault_d       = (state_d == FAULT);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RESET_PLL;
            cnt_q         <= RST_LOAD;
            retry_q       <= '0;
            pll_rst_q     <= 1'b1;
            video_rst_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_rst_q     <= pll_rst_d;
            video_rst_n_q <= video_rst_n_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign video_rst_n = video_rst_n_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

`ifdef VIDEO_PLL_SEQ_LOSS_COUNT_EN
    logic       loss_evt;
    logic [7:0] loss_q, loss_d;

    // A restart in the same cycle wins, so that cycle is not a lock-loss exit.
    assign loss_evt = (state_q == RUN) && !locked_s && !soft_restart;

    always_comb begin
        loss_d = loss_q;
        if (loss_evt && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) loss_q <= 8'd0;
        else        loss_q <= loss_d;
    end

    assign lock_loss_count = loss_q;
`endif

endmodule

// File: tb/tb_video_pll_lock_sequencer.sv
// Randomized and directed bench for video_pll_lock_sequencer against a phase/elapsed-time model.
module tb_video_pll_lock_sequencer;

    localparam int RP = 4;
    localparam int TO = 32;
    localparam int ST = 8;
    localparam int MR = 2;

    localparam int PH_RESET = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAULT = 4;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock_want = 1'b0;
    logic       soft_restart = 1'b0;
    logic       pll_locked;
    logic       pll_rst, video_rst_n, ready, fault;
    logic [1:0] retry_count;
`ifdef VIDEO_PLL_SEQ_LOSS_COUNT_EN
    logic [7:0] lock_loss_count;
`endif

    // The PLL can only report lock while it is out of reset.
    assign pll_locked = lock_want & ~pll_rst;

    video_pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_restart (soft_restart),
        .pll_rst      (pll_rst),
        .video_rst_n  (video_rst_n),
        .ready        (ready),
        .fault        (fault),
`ifdef VIDEO_PLL_SEQ_LOSS_COUNT_EN
        .lock_loss_count (lock_loss_count),
`endif
        .retry_count  (retry_count)
    );

    always #10 refclk = ~refclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: current phase, edges spent in it, failed attempts, lock losses.
    int   m_phase, m_el, m_ret, m_loss;
    logic m_s1, m_s2;
    logic in_lock, in_soft, in_rst;

    task automatic model_reset();
        m_phase = PH_RESET;
        m_el    = 0;
        m_ret   = 0;
        m_loss  = 0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
    endtask

    task automatic model_step();
        logic ls;
        if (!in_rst) begin
            model_reset();
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = in_lock;
        if (in_soft) begin
            m_phase = PH_RESET; m_el = 0; m_ret = 0;
        end else begin
            case (m_phase)
                PH_RESET: begin
                    m_el++;
                    if (m_el == RP) begin m_phase = PH_WAIT; m_el = 0; end
                end
                PH_WAIT: begin
                    if (ls) begin
                        m_phase = PH_STAB; m_el = 0;
                    end else begin
                        m_el++;
                        if (m_el == TO) begin
                            m_ret++;
                            m_phase = (m_ret == MR) ? PH_FAULT : PH_RESET;
                            m_el = 0;
                        end
                    end
                end
                PH_STAB: begin
                    if (!ls) begin
                        m_phase = PH_WAIT; m_el = 0;
                    end else begin
                        m_el++;
                        if (m_el == ST) begin m_phase = PH_RUN; m_el = 0; m_ret = 0; end
                    end
                end
                PH_RUN: begin
                    if (!ls) begin
                        m_phase = PH_RESET; m_el = 0;
                        if (m_loss < 255) m_loss++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_cycle();
        logic [5:0] exp;
        exp = {(m_phase == PH_RESET) || (m_phase == PH_FAULT),
               m_phase == PH_RUN, m_phase == PH_RUN, m_phase == PH_FAULT, 2'(m_ret)};
        check("cycle_outputs", {26'd0, pll_rst, video_rst_n, ready, fault, retry_count}, {26'd0, exp});
`ifdef VIDEO_PLL_SEQ_LOSS_COUNT_EN
        check("cycle_loss_count", {24'd0, lock_loss_count}, 32'(m_loss));
`endif
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        #1;
        in_lock = pll_locked;
        in_soft = soft_restart;
        in_rst  = rst_n;
        @(posedge refclk);
        model_step();
        @(negedge refclk);
        check_cycle();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        check({tag, "_others"}, {28'd0, video_rst_n, ready, fault, 1'b0} | 32'(retry_count), 32'd0);
`ifdef VIDEO_PLL_SEQ_LOSS_COUNT_EN
        check({tag, "_loss"}, 32'(lock_loss_count), 32'd0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_ready, saw_retry;
        bit   found;
        int   seg;

        model_reset();
        repeat (3) @(negedge refclk);
        check_reset_values("por");

        // Power-up with the PLL locking as soon as it is released.
        lock_want = 1'b1;
        rst_n     = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 3)  check("pwr_pll_rst_held", 32'(pll_rst), 32'd1);
            if (i == 4)  check("pwr_pll_rst_released", 32'(pll_rst), 32'd0);
            if (i == 14) check("pwr_ready_early", 32'(ready), 32'd0);
            if (i == 15) begin
                check("pwr_ready", 32'(ready), 32'd1);
                check("pwr_video_rst_n", 32'(video_rst_n), 32'd1);
                check("pwr_retry", 32'(retry_count), 32'd0);
            end
        end
        repeat (5) tick();

        // Lock loss in RUN and recovery.
        lock_want = 1'b0;
        tick(); check("loss_t1_ready", 32'(ready), 32'd1);
        tick(); check("loss_t2_ready", 32'(ready), 32'd1);
        tick(); check("loss_t3_ready", 32'(ready), 32'd0);
        check("loss_t3_pll_rst", 32'(pll_rst), 32'd1);
        check("loss_t3_video_rst_n", 32'(video_rst_n), 32'd0);
        lock_want = 1'b1;
        repeat (20) tick();
        check("relock_ready", 32'(ready), 32'd1);
`ifdef VIDEO_PLL_SEQ_LOSS_COUNT_EN
        check("relock_loss_count", 32'(lock_loss_count), 32'd1);
`endif

        // Soft restart out of RUN; the PLL then never locks.
        soft_restart = 1'b1;
        lock_want    = 1'b0;
        tick();
        soft_restart = 1'b0;
        check("soft_pll_rst", 32'(pll_rst), 32'd1);
        check("soft_ready", 32'(ready), 32'd0);
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (i == 35) check("nolock_retry0", 32'(retry_count), 32'd0);
            if (i == 36) check("nolock_retry1", 32'(retry_count), 32'd1);
            if (i == 71) check("nolock_no_fault_yet", 32'(fault), 32'd0);
            if (i == 72) check("nolock_retry2", 32'(retry_count), 32'd2);
            if (i == 120) begin
                check("fault_held", 32'(fault), 32'd1);
                check("fault_pll_rst", 32'(pll_rst), 32'd1);
            end
        end
        soft_restart = 1'b1;
        tick();
        soft_restart = 1'b0;
        check("fault_clear", 32'(fault), 32'd0);
        check("fault_clear_retry", 32'(retry_count), 32'd0);
        check("fault_clear_pll_rst", 32'(pll_rst), 32'd1);

        // Lock chatter: 5 high / 1 low never qualifies.
        saw_ready = 1'b0;
        saw_retry = 1'b0;
        for (int i = 0; i < 120; i++) begin
            lock_want = (i % 6) != 5;
            tick();
            if (ready) saw_ready = 1'b1;
            if (retry_count != 2'd0) saw_retry = 1'b1;
        end
        check("chatter_no_run", 32'(saw_ready), 32'd0);
        check("chatter_no_retry", 32'(saw_retry), 32'd0);
        lock_want = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (m_ret == 1) found = 1'b1;
        end
        check("chatter_timeout_seen", 32'(found), 32'd1);
        check("chatter_timeout_retry", 32'(retry_count), 32'd1);

        // Soft restart coinciding with a WAIT_LOCK timeout.
        found = (m_phase == PH_WAIT && m_el == TO - 1);
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (m_phase == PH_WAIT && m_el == TO - 1) found = 1'b1;
        end
        check("collide_setup", 32'(found), 32'd1);
        soft_restart = 1'b1;
        tick();
        soft_restart = 1'b0;
        check("collide_retry", 32'(retry_count), 32'd0);
        check("collide_pll_rst", 32'(pll_rst), 32'd1);
        check("collide_fault", 32'(fault), 32'd0);

        // Asynchronous reset in the middle of STABILIZE.
        lock_want = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (m_phase == PH_STAB && m_el == 3) found = 1'b1;
        end
        check("stab_setup", 32'(found), 32'd1);
        #5 rst_n = 1'b0;
        #1 check_reset_values("async");
        @(negedge refclk);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 14) check("rerun_ready_early", 32'(ready), 32'd0);
            if (i == 15) check("rerun_ready", 32'(ready), 32'd1);
        end

        // Randomized segments of lock/no-lock with sparse restarts and resets.
        seg = 0;
        for (int i = 0; i < 1500; i++) begin
            if (seg == 0) begin
                lock_want = ($urandom_range(0, 2) != 0);
                seg = lock_want ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 50));
            end
            seg--;
            soft_restart = ($urandom_range(0, 63) == 0);
            rst_n        = ($urandom_range(0, 299) != 0);
            tick();
        end
        soft_restart = 1'b0;
        rst_n        = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
